// File: rtl/otn_deframer_if.sv
// Payload byte stream from the deframer to the UART transmit path.
//   o_data  : payload byte
//   o_valid : o_data valid
//   i_ready : consumer accepts o_data when o_valid && i_ready
interface otn_deframer_if;
  localparam int unsigned DATA_W = 8;

  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;

  modport master (output o_data, output o_valid, input i_ready);
  modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/otn_deframer.sv
// Receive-side OTN deframer and stop-and-wait ARQ responder.
// Hunts for 0x7E on the serial line, shifts in SEQ/payload/CRC (MSB first),
// checks CRC-8 (poly 0x07, init 0), acks good and duplicate frames, and drains
// accepted payload bytes over a valid/ready stream.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_otn_tx_data     : serial frame line, idles high
//   o_otn_rx_ack      : ack pulse back to the sender (ACK_LEN cycles)
//   rx_out            : payload byte stream (o_data/o_valid/i_ready)
//   o_crc_val         : CRC byte of the last completed frame
//   o_crc_err, o_dup  : one-cycle pulses for CRC mismatch / duplicate frame
module otn_deframer #(
  parameter int unsigned PAYLOAD_BYTES = 1,
  parameter int unsigned ACK_LEN       = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_otn_tx_data,
  output logic           o_otn_rx_ack,
  otn_deframer_if.master rx_out,
  output logic [7:0]     o_crc_val,
  output logic           o_crc_err,
  output logic           o_dup
);

  localparam int unsigned IDX_W    = $clog2(PAYLOAD_BYTES + 1);
  localparam int unsigned ACK_W    = $clog2(ACK_LEN + 1);
  localparam logic [7:0]  FLAG     = 8'h7E;
  localparam logic [7:0]  CRC_POLY = 8'h07;

  typedef enum logic [2:0] {HUNT, SEQ, PAYLOAD, CRC, CHECK} state_t;

  state_t           state;
  // Holds the 7 most recent line bits; with the current bit it forms the
  // 8-bit window (reset/clear value all ones).
  logic [6:0]       shreg;
  logic [2:0]       bit_cnt;
  logic [IDX_W-1:0] byte_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [7:0]       crc_calc;
  logic [7:0]       seq_rx;
  logic [7:0]       crc_rx;
  logic [7:0]       last_seq;
  logic             last_valid;
  logic [ACK_W-1:0] ack_cnt;
  logic [7:0]       shadow [PAYLOAD_BYTES];
  logic [7:0]       drain  [PAYLOAD_BYTES];

  logic [7:0]       sh_next;
  logic [7:0]       crc_next;
  logic             frame_ok;
  logic             is_dup;
  logic             is_accept;
  logic [ACK_W-1:0] ack_next;

  // Line window, bitwise CRC step, and CHECK-cycle outcome decode.
  always_comb begin
    sh_next   = {shreg, i_otn_tx_data};
    crc_next  = {crc_calc[6:0], 1'b0} ^ ((crc_calc[7] ^ i_otn_tx_data) ? CRC_POLY : 8'h00);
    // A busy drain buffer (overrun) suppresses both dup and accept.
    frame_ok  = (state == CHECK) && (crc_calc == crc_rx) && !rx_out.o_valid;
    is_dup    = frame_ok && last_valid && (seq_rx == last_seq);
    is_accept = frame_ok && !is_dup;
    ack_next  = (ack_cnt != '0) ? ack_cnt - ACK_W'(1) : '0;
    if (is_dup || is_accept) ack_next = ACK_W'(ACK_LEN);
  end

  // Frame FSM, drain stream and ack counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= HUNT;
      shreg          <= 7'h7F;
      bit_cnt        <= '0;
      byte_idx       <= '0;
      rd_idx         <= '0;
      crc_calc       <= '0;
      seq_rx         <= '0;
      crc_rx         <= '0;
      last_seq       <= '0;
      last_valid     <= 1'b0;
      ack_cnt        <= '0;
      o_otn_rx_ack   <= 1'b0;
      rx_out.o_data  <= '0;
      rx_out.o_valid <= 1'b0;
      o_crc_val      <= '0;
      o_crc_err      <= 1'b0;
      o_dup          <= 1'b0;
    end else begin
      o_crc_err    <= 1'b0;
      o_dup        <= 1'b0;
      ack_cnt      <= ack_next;
      o_otn_rx_ack <= (ack_next != '0);

      if (rx_out.o_valid && rx_out.i_ready) begin
        if (rd_idx == IDX_W'(PAYLOAD_BYTES)) begin
          rx_out.o_valid <= 1'b0;
        end else begin
          rx_out.o_data <= drain[rd_idx];
          rd_idx        <= rd_idx + IDX_W'(1);
        end
      end

      case (state)
        HUNT: begin
          shreg <= sh_next[6:0];
          if (sh_next == FLAG) begin
            state    <= SEQ;
            bit_cnt  <= '0;
            crc_calc <= '0;
          end
        end
        SEQ: begin
          shreg    <= sh_next[6:0];
          crc_calc <= crc_next;
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            seq_rx   <= sh_next;
            byte_idx <= '0;
            state    <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          shreg    <= sh_next[6:0];
          crc_calc <= crc_next;
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            shadow[byte_idx] <= sh_next;
            if (byte_idx == IDX_W'(PAYLOAD_BYTES - 1)) state <= CRC;
            else byte_idx <= byte_idx + IDX_W'(1);
          end
        end
        CRC: begin
          shreg   <= sh_next[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            crc_rx <= sh_next;
            state  <= CHECK;
          end
        end
        CHECK: begin
          // Keep the current line bit so a flag starting here is still found.
          shreg     <= {6'h3F, i_otn_tx_data};
          state     <= HUNT;
          o_crc_val <= crc_rx;
          o_crc_err <= (crc_calc != crc_rx);
          o_dup     <= is_dup;
          if (is_accept) begin
            last_seq       <= seq_rx;
            last_valid     <= 1'b1;
            for (int i = 0; i < int'(PAYLOAD_BYTES); i++) drain[i] <= shadow[i];
            rx_out.o_data  <= shadow[0];
            rx_out.o_valid <= 1'b1;
            rd_idx         <= IDX_W'(1);
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_otn_deframer.sv
// Bench for otn_deframer: directed test-plan frames followed by random frames,
// checked every cycle against a frame-level reference model.
module tb_otn_deframer;
  localparam int unsigned N    = 1;
  localparam int unsigned ACK  = 4;
  localparam int          FLEN = 8 * (N + 3);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       din = 1'b1;
  logic       ack, crc_err, dup;
  logic [7:0] crc_val;

  otn_deframer_if bus ();

  otn_deframer #(.PAYLOAD_BYTES(N), .ACK_LEN(ACK)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_otn_tx_data(din),
    .o_otn_rx_ack (ack),
    .rx_out       (bus),
    .o_crc_val    (crc_val),
    .o_crc_err    (crc_err),
    .o_dup        (dup)
  );

  typedef struct {
    int           t;     // step that carries the last CRC bit
    logic [7:0]   seq;
    logic [7:0]   crc;
    logic [127:0] pl;
  } frame_t;

  frame_t       frames[$];
  logic [7:0]   q[$];          // bytes the DUT should still present, in order
  int           checks = 0;
  int           failures = 0;
  int           step_n = 0;
  bit           checking = 0;
  bit           rdy = 1;
  bit           rand_rdy = 0;
  bit           zero_data = 0;
  int           ack_lo = 1, ack_hi = 0;
  int           err_step = -1, dup_step = -1, push_step = -1, crc_step = -1;
  logic [7:0]   crc_pend, exp_crc_val = 8'h00, last_seq = 8'h00;
  bit           last_valid = 0;
  logic [127:0] push_pl;

  function automatic logic [7:0] crc8(input logic [7:0] seq, input logic [127:0] pl);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    for (int i = 0; i <= int'(N); i++) begin
      b = (i == 0) ? seq : pl[8*(i-1) +: 8];
      c = c ^ b;
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%02h expected=%02h", tag, step_n, obs, exp);
    end
  endtask

  task automatic clear_model();
    q.delete();
    frames.delete();
    ack_lo = 1; ack_hi = 0;
    err_step = -1; dup_step = -1; push_step = -1; crc_step = -1;
    exp_crc_val = 8'h00;
    last_valid = 0;
    zero_data = 1;
  endtask

  // Outcome of a completed frame, decided in its check cycle m (= T+1).
  task automatic decide(input frame_t f, input int m);
    crc_step = m + 1;
    crc_pend = f.crc;
    if (crc8(f.seq, f.pl) != f.crc) begin
      err_step = m + 1;
    end else if (q.size() > 0) begin
      // receiver still draining: frame silently dropped
    end else if (last_valid && f.seq == last_seq) begin
      dup_step = m + 1;
      ack_lo = m + 1; ack_hi = m + int'(ACK);
    end else begin
      last_seq = f.seq; last_valid = 1;
      ack_lo = m + 1; ack_hi = m + int'(ACK);
      push_step = m + 1; push_pl = f.pl;
    end
  endtask

  // One clock: check outputs of this cycle, then drive this cycle's inputs.
  task automatic step(input logic b, input logic r);
    int m;
    @(negedge clk);
    m = step_n;
    if (push_step == m) begin
      for (int i = 0; i < int'(N); i++) q.push_back(push_pl[8*i +: 8]);
      push_step = -1;
    end
    if (crc_step == m) begin
      exp_crc_val = crc_pend;
      crc_step = -1;
    end
    if (checking) begin
      chk("ack", 8'(ack), 8'(m >= ack_lo && m <= ack_hi));
      chk("crc_err", 8'(crc_err), 8'(m == err_step));
      chk("dup", 8'(dup), 8'(m == dup_step));
      chk("crc_val", crc_val, exp_crc_val);
      chk("valid", 8'(bus.o_valid), 8'(q.size() > 0));
      if (q.size() > 0) chk("data", bus.o_data, q[0]);
      else if (zero_data) chk("rst_data", bus.o_data, 8'h00);
    end
    zero_data = 0;
    if (frames.size() > 0 && frames[0].t + 1 == m) decide(frames.pop_front(), m);
    if (rand_rdy) rdy = ($urandom_range(3) != 0);
    rst = r;
    din = b;
    bus.i_ready = rdy;
    if (r) clear_model();
    else if (q.size() > 0 && rdy) void'(q.pop_front());
    step_n++;
    checking = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] seq, input logic [127:0] pl,
                            input logic [7:0] crc, input int rst_at);
    frame_t     f;
    logic [7:0] bytes[$];
    logic [7:0] cur;
    int         idx;
    f.t = step_n + FLEN - 1; f.seq = seq; f.pl = pl; f.crc = crc;
    frames.push_back(f);
    bytes.push_back(8'h7E);
    bytes.push_back(seq);
    for (int i = 0; i < int'(N); i++) bytes.push_back(pl[8*i +: 8]);
    bytes.push_back(crc);
    idx = 0;
    for (int j = 0; j < bytes.size(); j++) begin
      cur = bytes[j];
      for (int k = 7; k >= 0; k--) begin
        step(cur[k], idx == rst_at);
        idx++;
      end
    end
  endtask

  task automatic send_good(input logic [7:0] seq, input logic [127:0] pl);
    send_frame(seq, pl, crc8(seq, pl), -1);
  endtask

  initial begin
    logic [7:0]   seq;
    logic [127:0] pl;
    logic [7:0]   crc;
    bus.i_ready = 1'b1;

    step(1'b1, 1'b1); step(1'b1, 1'b1); idle(4);

    // Basic good frame
    send_frame(8'h00, 128'h41, 8'hC0, -1); idle(12);

    // Bad CRC, then the correct frame after a fresh start
    step(1'b1, 1'b1); idle(3);
    send_frame(8'h00, 128'h41, 8'hC1, -1); idle(12);
    send_frame(8'h00, 128'h41, 8'hC0, -1); idle(12);

    // Duplicate of the last accepted frame
    send_frame(8'h00, 128'h41, 8'hC0, -1); idle(12);

    // Overrun while downstream is stalled, then drain and resend
    step(1'b1, 1'b1); idle(3);
    rdy = 0;
    send_good(8'h00, 128'h41); idle(6);
    send_good(8'h01, 128'h42); idle(12);
    rdy = 1; idle(4);
    send_good(8'h01, 128'h42); idle(12);

    // Flag pattern as payload data
    send_good(8'h02, 128'h7E); idle(12);

    // Reset in the middle of the payload, then reuse the last SEQ
    send_frame(8'h00, 128'hFF, 8'hF3, 19); idle(8);
    send_good(8'h02, 128'h55); idle(12);

    // Random frames, gaps (including zero) and downstream stalls
    rand_rdy = 1;
    repeat (40) begin
      seq = 8'($urandom_range(3));
      pl  = {$urandom, $urandom, $urandom, $urandom};
      crc = crc8(seq, pl);
      if ($urandom_range(4) == 0) crc = crc ^ 8'(1 << $urandom_range(7));
      send_frame(seq, pl, crc, -1);
      idle($urandom_range(3));
    end
    rand_rdy = 0;
    rdy = 1;
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
